// File: rtl/bl_zone_sender_if.sv
// Zone-write and SPI-side signal bundle for bl_zone_sender.
// The producer/bench holds the master view and the sender holds the slave view.
interface bl_zone_sender_if;
  logic        zone_valid;
  logic [8:0]  zone_idx;
  logic [7:0]  zone_val;
  logic        frame_sync;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        tx_busy;
  logic        overrun;
  logic [15:0] frame_cnt;

  modport master (
    output zone_valid, zone_idx, zone_val, frame_sync,
    input  spi_cs_n, spi_sclk, spi_mosi, tx_busy, overrun, frame_cnt
  );

  modport slave (
    input  zone_valid, zone_idx, zone_val, frame_sync,
    output spi_cs_n, spi_sclk, spi_mosi, tx_busy, overrun, frame_cnt
  );
endinterface

// File: rtl/bl_zone_sender.sv
// Double-buffered 360-zone backlight RAM, sent once per frame to the LED driver
// as header, zone bytes, checksum over a write-only SPI mode-0 link.
module bl_zone_sender #(
  parameter int         CLK_DIV = 4,
  parameter int         ZONES   = 360,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic          i_pix_clk,
  input  logic          rst,
  bl_zone_sender_if.slave bus
);
  localparam int             AW        = 9;
  localparam logic [7:0]     DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [AW-1:0]  ZONE_CNT  = AW'(ZONES);
  localparam logic [AW-1:0]  LAST_ZONE = AW'(ZONES - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_NEXT, S_STOP} state_t;
  state_t state_reg, state_next;

  logic          wr_bank_reg;
  logic [7:0]    div_cnt_reg;
  logic          sclk_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    sh_reg;
  logic [7:0]    csum_reg;
  logic [AW-1:0] addr_reg;
  logic [AW-1:0] data_cnt_reg;
  logic          last_reg;
  logic          cs_n_reg;
  logic          busy_reg;
  logic          overrun_reg;
  logic [15:0]   frame_cnt_reg;

  logic          div_end, wr_en;
  logic          accept, ovr_set, ld_hdr, ld_data, ld_csum, shift_en, stop_done;
  logic [7:0]    rd_data [2];
  logic [7:0]    tx_byte;

  assign div_end = (div_cnt_reg == DIV_LAST);
  assign wr_en   = bus.zone_valid && (bus.zone_idx < ZONE_CNT);

  // Bank gi is written while wr_bank selects it and is read (continuously, one
  // cycle latency) while the other bank is being filled.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [7:0] mem [ZONES];
    always_ff @(posedge i_pix_clk) begin
      if (wr_en && (wr_bank_reg == 1'(gi)))
        mem[bus.zone_idx] <= bus.zone_val;
      rd_data[gi] <= mem[addr_reg];
    end
  end

  assign tx_byte = wr_bank_reg ? rd_data[0] : rd_data[1];

  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_START;
      S_START: state_next = S_SHIFT;
      S_SHIFT: if (shift_en && (bit_cnt_reg == 3'd7)) state_next = S_NEXT;
      S_NEXT:  state_next = (ld_data || ld_csum) ? S_SHIFT : S_STOP;
      S_STOP:  if (stop_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    accept    = 1'b0;
    ld_hdr    = 1'b0;
    ld_data   = 1'b0;
    ld_csum   = 1'b0;
    shift_en  = 1'b0;
    stop_done = 1'b0;
    ovr_set   = bus.frame_sync && (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE:  accept = bus.frame_sync;
      S_START: ld_hdr = 1'b1;
      // shift on the sclk falling edge so mosi only moves while sclk is low
      S_SHIFT: shift_en = div_end && sclk_reg;
      S_NEXT: begin
        if (data_cnt_reg != ZONE_CNT) ld_data = 1'b1;
        else if (!last_reg)           ld_csum = 1'b1;
      end
      S_STOP:  stop_done = div_end;
      default: ;
    endcase
  end

  always_ff @(posedge i_pix_clk or posedge rst) begin
    if (rst) begin
      wr_bank_reg   <= 1'b0;
      div_cnt_reg   <= '0;
      sclk_reg      <= 1'b0;
      bit_cnt_reg   <= '0;
      sh_reg        <= '0;
      csum_reg      <= '0;
      addr_reg      <= '0;
      data_cnt_reg  <= '0;
      last_reg      <= 1'b0;
      cs_n_reg      <= 1'b1;
      busy_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      if (accept)  wr_bank_reg <= ~wr_bank_reg;
      if (ovr_set) overrun_reg <= 1'b1;

      if (((state_reg == S_SHIFT) || (state_reg == S_STOP)) && !div_end)
        div_cnt_reg <= div_cnt_reg + 8'd1;
      else
        div_cnt_reg <= '0;

      if (state_reg != S_SHIFT) sclk_reg <= 1'b0;
      else if (div_end)         sclk_reg <= ~sclk_reg;

      if (ld_hdr || ld_data || ld_csum) bit_cnt_reg <= '0;
      else if (shift_en)                bit_cnt_reg <= bit_cnt_reg + 3'd1;

      if (ld_hdr)        sh_reg <= HEADER;
      else if (ld_data)  sh_reg <= tx_byte;
      else if (ld_csum)  sh_reg <= csum_reg;
      else if (shift_en) sh_reg <= {sh_reg[6:0], 1'b0};

      if (ld_hdr) begin
        csum_reg     <= '0;
        addr_reg     <= '0;
        data_cnt_reg <= '0;
        last_reg     <= 1'b0;
      end else if (ld_data) begin
        csum_reg     <= csum_reg + tx_byte;
        data_cnt_reg <= data_cnt_reg + 1'b1;
        if (addr_reg != LAST_ZONE) addr_reg <= addr_reg + 1'b1;
      end else if (ld_csum) begin
        last_reg     <= 1'b1;
      end

      if (ld_hdr) begin
        cs_n_reg <= 1'b0;
        busy_reg <= 1'b1;
      end else if (stop_done) begin
        cs_n_reg      <= 1'b1;
        busy_reg      <= 1'b0;
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.spi_cs_n  = cs_n_reg;
  assign bus.spi_sclk  = sclk_reg;
  assign bus.spi_mosi  = sh_reg[7];
  assign bus.tx_busy   = busy_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.frame_cnt = frame_cnt_reg;
endmodule

// File: tb/tb_bl_zone_sender.sv
// Bench for bl_zone_sender: two instances (CLK_DIV 4 and 2), SPI capture monitor,
// and a bank/frame reference model built from the zone-map rules.
module tb_bl_zone_sender;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bl_zone_sender_if if_a ();
  bl_zone_sender_if if_b ();

  bl_zone_sender #(.CLK_DIV(4)) dut_a (.i_pix_clk(clk), .rst(rst), .bus(if_a.slave));
  bl_zone_sender #(.CLK_DIV(2)) dut_b (.i_pix_clk(clk), .rst(rst), .bus(if_b.slave));

  int checks = 0;
  int errors = 0;

  // Reference model: two zone banks, the write-bank pointer, and the frame expected on the wire.
  logic [7:0] bank [2][360];
  int         wr_m = 0;
  logic [7:0] exp_f [362];

  // SPI capture, index 0 = dut_a, 1 = dut_b.
  logic       cs_v [2];
  logic       sck_v [2];
  logic       mo_v [2];
  assign cs_v[0] = if_a.spi_cs_n;  assign sck_v[0] = if_a.spi_sclk;  assign mo_v[0] = if_a.spi_mosi;
  assign cs_v[1] = if_b.spi_cs_n;  assign sck_v[1] = if_b.spi_sclk;  assign mo_v[1] = if_b.spi_mosi;

  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  int         len_m [2]   = '{0, 0};
  int         done_m [2]  = '{0, 0};
  int         nb_m [2]    = '{0, 0};
  int         hi_cnt [2]  = '{0, 0};
  int         hi_min [2]  = '{1000, 1000};
  int         hi_max [2]  = '{0, 0};
  logic [7:0] sh_m [2]    = '{8'h00, 8'h00};
  logic       prev_cs [2] = '{1'b1, 1'b1};
  logic       prev_sck [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cs_v[d] === 1'b0) begin
        if (prev_cs[d]) begin
          len_m[d] = 1;
          nb_m[d]  = 0;
          if (d == 0) rx_a.delete(); else rx_b.delete();
        end else begin
          len_m[d]++;
        end
        if (sck_v[d]) begin
          if (!prev_sck[d]) begin
            sh_m[d] = {sh_m[d][6:0], mo_v[d]};
            nb_m[d]++;
            hi_cnt[d] = 0;
            if (nb_m[d] == 8) begin
              if (d == 0) rx_a.push_back(sh_m[d]); else rx_b.push_back(sh_m[d]);
              nb_m[d] = 0;
            end
          end
          hi_cnt[d]++;
        end else if (prev_sck[d]) begin
          if (hi_cnt[d] < hi_min[d]) hi_min[d] = hi_cnt[d];
          if (hi_cnt[d] > hi_max[d]) hi_max[d] = hi_cnt[d];
        end
      end else if (cs_v[d] === 1'b1 && !prev_cs[d] && !rst) begin
        done_m[d]++;
      end
      prev_cs[d]  = (cs_v[d] === 1'b0) ? 1'b0 : 1'b1;
      prev_sck[d] = (sck_v[d] === 1'b1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus; the model applies the write, then any accepted frame_sync.
  task automatic step(input bit v, input int idx, input logic [7:0] val,
                      input bit fa, input bit fb, input bit acc);
    int sum;
    @(negedge clk);
    if_a.zone_valid = v;  if_b.zone_valid = v;
    if_a.zone_idx   = idx[8:0];  if_b.zone_idx = idx[8:0];
    if_a.zone_val   = val;  if_b.zone_val = val;
    if_a.frame_sync = fa;  if_b.frame_sync = fb;
    if (v && idx < 360) bank[wr_m][idx] = val;
    if (fb && acc) begin
      sum = 0;
      exp_f[0] = 8'hA5;
      for (int z = 0; z < 360; z++) begin
        exp_f[z + 1] = bank[wr_m][z];
        sum += int'(bank[wr_m][z]);
      end
      exp_f[361] = 8'(sum % 256);
      wr_m = 1 - wr_m;
    end
  endtask

  task automatic idle();
    step(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input int d, input int target, input string tag);
    int n = 0;
    while (done_m[d] < target && n < 40000) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, done_m[d], target);
  endtask

  function automatic logic [7:0] rx_at(input int d, input int i);
    if (d == 0) return (i < rx_a.size()) ? rx_a[i] : 8'hxx;
    return (i < rx_b.size()) ? rx_b[i] : 8'hxx;
  endfunction

  task automatic check_frame(input string tag, input int d);
    int nbad = 0;
    int first = -1;
    int sz = (d == 0) ? rx_a.size() : rx_b.size();
    for (int i = 0; i < 362; i++) begin
      if (rx_at(d, i) !== exp_f[i]) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    chk({tag, "_len"}, sz, 362);
    chk($sformatf("%s_bad_bytes(first@%0d)", tag, first), nbad, 0);
  endtask

  initial begin
    logic [7:0] rv;
    if_a.zone_valid = 1'b0;  if_a.zone_idx = '0;  if_a.zone_val = '0;  if_a.frame_sync = 1'b0;
    if_b.zone_valid = 1'b0;  if_b.zone_idx = '0;  if_b.zone_val = '0;  if_b.frame_sync = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n",   if_a.spi_cs_n, 1);
    chk("rst_sclk",   if_a.spi_sclk, 0);
    chk("rst_mosi",   if_a.spi_mosi, 0);
    chk("rst_busy",   if_a.tx_busy, 0);
    chk("rst_ovr",    if_a.overrun, 0);
    chk("rst_fcnt",   if_a.frame_cnt, 0);
    rst = 1'b0;

    // Frame 1 on both instances: zone i = i[7:0]; sum of those over 0..359 is 8'h6C.
    for (int i = 0; i < 360; i++) step(1'b1, i, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b1);
    idle();
    chk("a_T1_cs_n", if_a.spi_cs_n, 1);
    chk("b_T1_cs_n", if_b.spi_cs_n, 1);
    idle();
    chk("a_T2_cs_n", if_a.spi_cs_n, 0);
    chk("a_T2_busy", if_a.tx_busy, 1);
    chk("a_T2_mosi", if_a.spi_mosi, 1);
    chk("b_T2_cs_n", if_b.spi_cs_n, 0);
    chk("b_T2_mosi", if_b.spi_mosi, 1);
    // Fill the other bank while frame 1 is on the wire.
    for (int i = 0; i < 360; i++) step(1'b1, i, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle();
    wait_done(0, 1, "a_f1_done");
    wait_done(1, 1, "b_f1_done");
    check_frame("a_f1", 0);
    chk("a_f1_hdr", rx_at(0, 0), 8'hA5);
    chk("a_f1_last_zone", rx_at(0, 360), 8'h67);
    chk("a_f1_csum", rx_at(0, 361), 8'h6C);
    chk("a_f1_cs_len", len_m[0], 23534);
    chk("a_f1_fcnt", if_a.frame_cnt, 1);
    chk("a_f1_busy", if_a.tx_busy, 0);
    chk("a_sclk_hi_min", hi_min[0], 4);
    chk("a_sclk_hi_max", hi_max[0], 4);
    check_frame("b_f1", 1);
    chk("b_f1_csum", rx_at(1, 361), 8'h6C);
    chk("b_f1_cs_len", len_m[1], 11948);
    chk("b_f1_fcnt", if_b.frame_cnt, 1);
    chk("b_sclk_hi_min", hi_min[1], 2);
    chk("b_sclk_hi_max", hi_max[1], 2);

    // Frame 2 on dut_b: all 3C; meanwhile random fill, boundary writes and an overrun pulse.
    step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 360; i++) step(1'b1, i, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    step(1'b1, 360, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 511, 8'hFF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 359, 8'h80, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle();
    chk("f2_overrun_set", if_b.overrun, 1);
    chk("f2_still_busy", if_b.tx_busy, 1);
    wait_done(1, 2, "f2_done");
    check_frame("f2", 1);
    chk("f2_csum", rx_at(1, 361), 8'h60);
    chk("f2_fcnt", if_b.frame_cnt, 2);
    repeat (50) idle();
    chk("f2_fcnt_once", if_b.frame_cnt, 2);
    chk("f2_no_restart", if_b.tx_busy, 0);
    chk("f2_overrun_sticky", if_b.overrun, 1);

    // Frame 3: bank with boundary writes plus a write in the same cycle as frame_sync.
    rv = 8'($urandom_range(0, 255));
    step(1'b1, 7, rv, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 360; i++) step(1'b1, i, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    idle();
    wait_done(1, 3, "f3_done");
    check_frame("f3", 1);
    chk("f3_zone7_same_cycle", rx_at(1, 8), rv);
    chk("f3_last_zone", rx_at(1, 360), 8'h80);
    chk("f3_fcnt", if_b.frame_cnt, 3);
    chk("f3_overrun", if_b.overrun, 1);

    // Frame 4: reset asynchronously once 100 bytes are out.
    step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle();
    begin
      int n = 0;
      while (rx_b.size() < 100 && n < 20000) begin
        @(negedge clk); #1;
        n++;
      end
    end
    chk("f4_reached_byte100", 32'(rx_b.size() >= 100), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cs_n", if_b.spi_cs_n, 1);
    chk("arst_sclk", if_b.spi_sclk, 0);
    chk("arst_busy", if_b.tx_busy, 0);
    chk("arst_fcnt", if_b.frame_cnt, 0);
    chk("arst_ovr", if_b.overrun, 0);
    chk("arst_a_fcnt", if_a.frame_cnt, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wr_m = 0;

    // Frame 5: fresh frame after reset.
    for (int i = 0; i < 360; i++) step(1'b1, i, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle();
    wait_done(1, 4, "f5_done");
    check_frame("f5", 1);
    chk("f5_hdr", rx_at(1, 0), 8'hA5);
    chk("f5_fcnt", if_b.frame_cnt, 1);
    chk("f5_overrun", if_b.overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
